alu_seq: RTL

- Parametrised, registered successor to the single-cycle datapath ALU.
- Supports the same operation set at configurable WIDTH.
- Adds a valid/ready handshake on input and output, a flag for every operation, an error flag for illegal codes, and an iterative full-width multiply (shift-add, one bit per cycle).
- Sits between the ID/EX operand latches and the EX/MEM stage; the stall unit uses in_ready and out_valid.

---
 rtl/alu_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier that retires one multiplier bit per clock.
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter int CTRL_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [CTRL_BITS-1:0] op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 zero,
    output logic                 ovf,
    output logic                 err
);

    localparam logic [CTRL_BITS-1:0] OP_AND = CTRL_BITS'(4'b0000);
    localparam logic [CTRL_BITS-1:0] OP_OR  = CTRL_BITS'(4'b0001);
    localparam logic [CTRL_BITS-1:0] OP_ADD = CTRL_BITS'(4'b0010);
    localparam logic [CTRL_BITS-1:0] OP_SUB = CTRL_BITS'(4'b0110);
    localparam logic [CTRL_BITS-1:0] OP_SLT = CTRL_BITS'(4'b0111);
    localparam logic [CTRL_BITS-1:0] OP_MUL = CTRL_BITS'(4'b1000);
    localparam logic [CTRL_BITS-1:0] OP_NOR = CTRL_BITS'(4'b1100);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     sum, diff, alu_res;
    logic                 alu_ovf, alu_err;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 accept;

    assign sum  = src1 + src2;
    assign diff = src1 - src2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            // Direct signed compare, so wraparound of src1-src2 cannot flip the answer
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_NOR: alu_res = ~(src1 | src2);
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = MUL_RUN;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, src1};
                        mplier_d = src2;
                        cnt_d    = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        hi_d     = '0;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last bit: publish the product taken straight from the adder
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = prod_next[WIDTH-1:0];
                    hi_d     = prod_next[2*WIDTH-1:WIDTH];
                    zero_d   = (prod_next[WIDTH-1:0] == '0);
                    ovf_d    = (prod_next[2*WIDTH-1:WIDTH] != '0);
                    err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
